voice_allocator: RTL
====================

# voice_allocator

Polyphonic voice allocator sitting downstream of the touch-key note decoder. It consumes the per-key gate and trigger vectors and assigns pressed keys to a fixed pool of synthesis voices. For each voice it drives an active flag, a key index and a one-cycle retrigger pulse. When the pool is full it steals a voice in round-robin order.

## Interface

Parameters:
- NUM_KEYS, 24: number of key lines on gate_in / trigger_in.
- NUM_VOICES, 4: voice pool size; legal range 1..8.
- KEY_W, 5: key index width; must satisfy 2^KEY_W >= NUM_KEYS.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- rst_in  input  1  reset; asynchronous, active-low (0 = reset).
- gate_in  input  NUM_KEYS  level, 1 = key currently held.
- trigger_in  input  NUM_KEYS  one-cycle press pulses; may assert on several keys in the same cycle.
- voice_active_out  output  NUM_VOICES  1 = voice v is sounding.
- voice_key_out  output  NUM_VOICES*KEY_W  key index of voice v, held in bits [v*KEY_W +: KEY_W].
- voice_trig_out  output  NUM_VOICES  one-cycle pulse when voice v is (re)assigned or retriggered.
- steal_out  output  1  one-cycle pulse when an active voice was stolen.
- busy_out  output  1  1 while FSM is in SCAN.

## Operation

- Pending register: every cycle, pending_next = (pending & ~serviced_mask) | trigger_in. A new trigger on the key being serviced in the same cycle leaves that key's pending bit set.
- FSM states:
  - IDLE: scan pointer parked at 0.
  - SCAN: pointer k advances by 1 per cycle and wraps from NUM_KEYS-1 to 0.
- IDLE -> SCAN when (pending | trigger_in) != 0.
- SCAN -> IDLE on the cycle k wraps, if pending == 0, no voice is active, and trigger_in == 0.
- Service of key k in SCAN, in priority order, within one cycle:
  1. Release: every active voice with key == k and gate_in[k] == 0 is deactivated.
  2. If pending[k] and gate_in[k] == 0: clear pending[k]; no voice action (tap discarded).
  3. If pending[k] and an active voice already holds k: pulse that voice's trig; clear pending[k].
  4. Else if pending[k] and a free voice exists: the lowest-index inactive voice gets key = k, active = 1, trig pulse; clear pending[k]. A voice freed by step 1 in the same cycle counts as free.
  5. Else if pending[k] and the pool is full: voice[steal_ptr] gets key = k, trig pulse, steal_out pulse; steal_ptr advances by 1 mod NUM_VOICES; clear pending[k].
- At most one key is serviced per cycle, so at most one voice_trig_out bit is high per cycle.
- Duplicate keys across voices are impossible by construction. Any voice_key_out value is < NUM_KEYS.

## Timing

- All outputs are registered.
- Reset values:
  - voice_active_out = 0, voice_key_out = 0, voice_trig_out = 0, steal_out = 0, busy_out = 0.
  - pending = 0, scan pointer = 0, steal_ptr = 0, FSM = IDLE.
- Latency:
  - trigger_in[k] at cycle t is visible in pending at t+1.
  - The key is serviced when the pointer reaches k. Worst case is t+NUM_KEYS from SCAN, or t+1+NUM_KEYS from IDLE.
  - Voice outputs change on the edge ending the service cycle.
- Release latency: the voice deactivates at most NUM_KEYS cycles after gate_in[k] falls, and only while in SCAN. SCAN cannot exit while any voice is active, so every release is eventually processed.
- voice_trig_out and steal_out are exactly one cycle wide. Back-to-back pulses on different voices in consecutive cycles are legal.
- Reset asserted mid-scan clears all state immediately (asynchronous). Outputs hold their reset values until the first clock edge after rst_in rises.
- trigger_in without gate_in is legal input and is handled by step 2.

## Test plan

- **Single press:** trigger_in[3] pulse, gate_in[3] held, from IDLE.
  - Voice 0 gets active = 1, key = 3, and a single trig pulse within 26 cycles; busy_out = 1.
  - After gate_in[3] = 0, voice 0 deactivates within 24 cycles, then busy_out returns to 0 at the next pointer wrap.
- **Chord fill:** triggers on keys 5, 9, 2, 7 in the same cycle, all gates held.
  - Voices 0..3 take keys 2, 5, 7, 9 (scan order from 0).
  - Four trig pulses on distinct cycles; steal_out never pulses.
- **Steal:** with the pool from the chord-fill scenario full, trigger key 11.
  - Voice 0 becomes key 11; steal_out pulses once.
  - A subsequent trigger on key 12 steals voice 1.
- **Retrigger:** with key 5 held on voice 1, pulse trigger_in[5] again.
  - Voice 1 trig pulses, key stays 5, no other voice changes.
- **Short tap:** trigger_in[8] with gate_in[8] dropping before service.
  - No voice activates; pending clears; FSM returns to IDLE after the wrap.
- **Async reset mid-scan:** rst_in = 0 with 2 voices active and pending bits set.
  - All outputs read 0 the same cycle, with no clock edge needed.
  - After release of reset, with no further stimulus, the block stays in IDLE.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator
//   Assigns pressed keys from the touch-key decoder to a fixed pool of synthesis
//   voices. Pending presses are serviced one key per cycle by a scan pointer.
//   The lowest free voice is used first. When no voice is free, voices are
//   stolen in round-robin order.
//
// Ports
//   clk_in            system clock, rising edge
//   rst_in            asynchronous reset, active low
//   gate_in           per-key level, 1 = key held
//   trigger_in        per-key one-cycle press pulses
//   voice_active_out  per-voice sounding flag
//   voice_key_out     per-voice key index, voice v in [v*KEY_W +: KEY_W]
//   voice_trig_out    per-voice one-cycle (re)assign / retrigger pulse
//   steal_out         one-cycle pulse when an active voice was taken over
//   busy_out          1 while the scan is running
module voice_allocator #(
    parameter int NUM_KEYS   = 24,
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 5
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_KEYS-1:0]           gate_in,
    input  logic [NUM_KEYS-1:0]           trigger_in,
    output logic [NUM_VOICES-1:0]         voice_active_out,
    output logic [NUM_VOICES*KEY_W-1:0]   voice_key_out,
    output logic [NUM_VOICES-1:0]         voice_trig_out,
    output logic                          steal_out,
    output logic                          busy_out
);

    localparam int VP_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [KEY_W-1:0] LAST_KEY  = KEY_W'(NUM_KEYS - 1);
    localparam logic [VP_W-1:0]  LAST_VOICE = VP_W'(NUM_VOICES - 1);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t                      state, state_nx;
    logic [KEY_W-1:0]            ptr, ptr_nx;
    logic [VP_W-1:0]             steal_ptr, steal_ptr_nx;
    logic [NUM_KEYS-1:0]         pending, pending_nx, serviced_mask;
    logic [NUM_VOICES-1:0]       active_nx, trig_nx;
    logic [NUM_VOICES*KEY_W-1:0] key_nx;
    logic                        steal_nx;
    logic                        hold_found, free_found;
    int                          hold_idx, free_idx;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can leave one unassigned and infer a latch.
        state_nx      = state;
        ptr_nx        = ptr;
        steal_ptr_nx  = steal_ptr;
        serviced_mask = '0;
        active_nx     = voice_active_out;
        key_nx        = voice_key_out;
        trig_nx       = '0;
        steal_nx      = 1'b0;
        hold_found    = 1'b0;
        hold_idx      = 0;
        free_found    = 1'b0;
        free_idx      = 0;

        if (state == SCAN) begin
            // Release first, so a voice freed here is available to the same key's press.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (voice_active_out[v] && voice_key_out[v*KEY_W +: KEY_W] == ptr && !gate_in[ptr])
                    active_nx[v] = 1'b0;
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (active_nx[v] && voice_key_out[v*KEY_W +: KEY_W] == ptr) begin
                    hold_found = 1'b1;
                    hold_idx   = v;
                end
            end
            // Descending walk leaves the lowest-index free voice selected.
            for (int v = NUM_VOICES - 1; v >= 0; v--) begin
                if (!active_nx[v]) begin
                    free_found = 1'b1;
                    free_idx   = v;
                end
            end

            if (pending[ptr]) begin
                serviced_mask[ptr] = 1'b1;
                // A press whose gate already dropped is a tap and is discarded.
                if (gate_in[ptr]) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (hold_found) begin
                            if (v == hold_idx) trig_nx[v] = 1'b1;
                        end else if (free_found) begin
                            if (v == free_idx) begin
                                active_nx[v]                = 1'b1;
                                key_nx[v*KEY_W +: KEY_W]    = ptr;
                                trig_nx[v]                  = 1'b1;
                            end
                        end else if (v == int'(steal_ptr)) begin
                            key_nx[v*KEY_W +: KEY_W] = ptr;
                            trig_nx[v]               = 1'b1;
                        end
                    end
                    if (!hold_found && !free_found) begin
                        steal_nx     = 1'b1;
                        steal_ptr_nx = (steal_ptr == LAST_VOICE) ? '0 : steal_ptr + 1'b1;
                    end
                end
            end
        end

        // A fresh trigger on the key being serviced re-arms it.
        pending_nx = (pending & ~serviced_mask) | trigger_in;

        case (state)
            IDLE: begin
                if ((pending | trigger_in) != '0) state_nx = SCAN;
            end
            SCAN: begin
                if (ptr == LAST_KEY) begin
                    ptr_nx = '0;
                    // Staying in SCAN while any voice sounds guarantees its release is seen.
                    if (pending_nx == '0 && active_nx == '0) state_nx = IDLE;
                end else begin
                    ptr_nx = ptr + 1'b1;
                end
            end
        endcase
    end

    // NOTE: all state uses non-blocking assignments so each flop samples the pre-edge values from the block above.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            ptr              <= '0;
            steal_ptr        <= '0;
            pending          <= '0;
            voice_active_out <= '0;
            voice_key_out    <= '0;
            voice_trig_out   <= '0;
            steal_out        <= 1'b0;
        end else begin
            state            <= state_nx;
            ptr              <= ptr_nx;
            steal_ptr        <= steal_ptr_nx;
            pending          <= pending_nx;
            voice_active_out <= active_nx;
            voice_key_out    <= key_nx;
            voice_trig_out   <= trig_nx;
            steal_out        <= steal_nx;
        end
    end

    // The state flop itself is the busy flag.
    assign busy_out = (state == SCAN);

endmodule
